// File: rtl/chip8_rand_byte_server.sv
// Purpose: decimates 16-bit random words into folded bytes, buffers them, serves CXNN requests.
// Latency: req seen high at edge k with a buffered byte -> ack pulse during the cycle after k.
// Backpressure: a full FIFO drops the sample; an empty FIFO parks the request in WAIT until a byte lands.
module chip8_rand_byte_server #(
   parameter int DEPTH         = 4,
   parameter int FILL_INTERVAL = 3
) (
   input  logic                     cpu_clk,
   input  logic                     reset,
   input  logic [15:0]              rand_in,
   input  logic                     req,
   input  logic [7:0]               mask,
   output logic                     ack,
   output logic [7:0]               rand_byte,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = (FILL_INTERVAL > 1) ? $clog2(FILL_INTERVAL) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ACK  = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   state_t          state;
   logic [CW-1:0]   samp_cnt;
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [7:0]      mem [DEPTH];

   logic            samp_last;
   logic            fifo_full;
   logic            fifo_empty;
   logic            push;
   logic            pop;
   logic [7:0]      fold_byte;

   // Push/pop decisions; both look at the registered level, so a byte pushed
   // on one edge can only be popped on a later edge.
   always_comb begin
      samp_last  = (samp_cnt == CW'(FILL_INTERVAL - 1));
      fifo_full  = (level == LW'(DEPTH));
      fifo_empty = (level == '0);
      fold_byte  = rand_in[15:8] ^ rand_in[7:0];
      push       = samp_last && !fifo_full;
      pop        = !fifo_empty && (((state == S_IDLE) && req) || (state == S_WAIT));
   end

   // Free-running decimation counter; wraps even when the sample is dropped.
   always_ff @(posedge cpu_clk or posedge reset) begin
      if (reset) begin
         samp_cnt <= '0;
      end else if (samp_last) begin
         samp_cnt <= '0;
      end else begin
         samp_cnt <= samp_cnt + CW'(1);
      end
   end

   // Circular byte buffer with registered occupancy.
   always_ff @(posedge cpu_clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr] <= fold_byte;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   // Request handshake; HOLD keeps a still-high req from consuming a second byte.
   always_ff @(posedge cpu_clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         ack       <= 1'b0;
         rand_byte <= '0;
      end else begin
         ack <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pop) begin
                  rand_byte <= mem[rd_ptr] & mask;
                  ack       <= 1'b1;
                  state     <= S_ACK;
               end else if (req) begin
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (pop) begin
                  rand_byte <= mem[rd_ptr] & mask;
                  ack       <= 1'b1;
                  state     <= S_ACK;
               end
            end
            S_ACK: begin
               state <= req ? S_HOLD : S_IDLE;
            end
            S_HOLD: begin
               if (!req) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_chip8_rand_byte_server.sv
// Directed bench for chip8_rand_byte_server at DEPTH=4, FILL_INTERVAL=3.
// Edges are numbered from reset release; inputs driven and outputs sampled 1ns after each edge.
module tb_chip8_rand_byte_server;

   logic        cpu_clk;
   logic        reset;
   logic [15:0] rand_in;
   logic        req;
   logic [7:0]  mask;
   logic        ack;
   logic [7:0]  rand_byte;
   logic [2:0]  level;

   int n_total;
   int n_pass;
   int ack_seen;

   chip8_rand_byte_server #(
      .DEPTH         (4),
      .FILL_INTERVAL (3)
   ) dut (
      .cpu_clk   (cpu_clk),
      .reset     (reset),
      .rand_in   (rand_in),
      .req       (req),
      .mask      (mask),
      .ack       (ack),
      .rand_byte (rand_byte),
      .level     (level)
   );

   initial cpu_clk = 1'b0;
   always #5 cpu_clk = ~cpu_clk;

   task automatic tick();
      @(posedge cpu_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      n_total  = 0;
      n_pass   = 0;
      ack_seen = 0;
      reset    = 1'b1;
      rand_in  = 16'hF5D2;
      req      = 1'b0;
      mask     = 8'h00;

      // Reset state
      tick();
      tick();
      check("rst_ack",   16'(ack),       16'h0);
      check("rst_byte",  16'(rand_byte), 16'h00);
      check("rst_level", 16'(level),     16'h0);

      // Fill: level 1,2,3,4 at edges 3,6,9,12 then saturates (edge 15 sample dropped)
      reset = 1'b0;
      for (int e = 1; e <= 15; e++) begin
         tick();
         check($sformatf("fill_level_e%0d", e), 16'(level), 16'((e / 3 > 4) ? 4 : e / 3));
      end
      check("fill_no_ack", 16'(ack), 16'h0);

      // Serve at edge 16 (no sample edge): 0x27 & 0x0F
      req  = 1'b1;
      mask = 8'h0F;
      tick();
      check("serve_ack",   16'(ack),       16'h1);
      check("serve_byte",  16'(rand_byte), 16'h07);
      check("serve_level", 16'(level),     16'h3);

      // Held req for 10 cycles (edges 17..26): no further ack, one refill at edge 18
      for (int i = 0; i < 10; i++) begin
         tick();
         if (ack) ack_seen++;
      end
      check("hold_acks",  16'(ack_seen),  16'h0);
      check("hold_level", 16'(level),     16'h4);
      check("hold_byte",  16'(rand_byte), 16'h07);

      // Drop req (edge 27 -> IDLE), reassert, pop at edge 28
      req = 1'b0;
      tick();
      req  = 1'b1;
      mask = 8'hFF;
      tick();
      check("reack_ack",   16'(ack),       16'h1);
      check("reack_byte",  16'(rand_byte), 16'h27);
      check("reack_level", 16'(level),     16'h3);
      req = 1'b0;
      tick();
      check("reack_pulse", 16'(ack),   16'h0);
      check("reack_lvl2",  16'(level), 16'h3);

      // Pop coinciding with sample edge 30 at level 3
      req  = 1'b1;
      mask = 8'h3C;
      tick();
      check("simul3_ack",   16'(ack),       16'h1);
      check("simul3_byte",  16'(rand_byte), 16'h24);
      check("simul3_level", 16'(level),     16'h3);

      // Reset mid-operation while ack=1 and level=3: clears without a clock
      reset = 1'b1;
      req   = 1'b0;
      #1;
      check("midrst_ack",   16'(ack),       16'h0);
      check("midrst_level", 16'(level),     16'h0);
      check("midrst_byte",  16'(rand_byte), 16'h00);
      tick();
      reset = 1'b0;

      // Refill timing as after the first reset
      for (int e = 1; e <= 8; e++) begin
         tick();
         check($sformatf("refill_level_e%0d", e), 16'(level), 16'(e / 3));
      end

      // Level 2, pop lands on sample edge 9: level unchanged
      req  = 1'b1;
      mask = 8'hF0;
      tick();
      check("simul2_ack",   16'(ack),       16'h1);
      check("simul2_byte",  16'(rand_byte), 16'h20);
      check("simul2_level", 16'(level),     16'h2);

      // Empty wait: req high straight out of reset
      reset = 1'b1;
      mask  = 8'hFF;
      #1;
      tick();
      reset = 1'b0;
      tick();
      check("wait_e1_ack",   16'(ack),   16'h0);
      check("wait_e1_level", 16'(level), 16'h0);
      tick();
      tick();
      check("wait_e3_ack",   16'(ack),   16'h0);
      check("wait_e3_level", 16'(level), 16'h1);
      tick();
      check("wait_e4_ack",   16'(ack),       16'h1);
      check("wait_e4_byte",  16'(rand_byte), 16'h27);
      check("wait_e4_level", 16'(level),     16'h0);
      tick();
      check("wait_e5_ack", 16'(ack), 16'h0);

      // mask 0x00 still consumes a byte (push at edge 6, pop at edge 7)
      req = 1'b0;
      tick();
      check("m0_pre_level", 16'(level), 16'h1);
      req  = 1'b1;
      mask = 8'h00;
      tick();
      check("m0_ack",   16'(ack),       16'h1);
      check("m0_byte",  16'(rand_byte), 16'h00);
      check("m0_level", 16'(level),     16'h0);

      // rand_in == 0 pushes byte 0x00 at edge 9; popped at edge 10 with mask 0xFF
      req     = 1'b0;
      rand_in = 16'h0000;
      tick();
      tick();
      check("z_pre_level", 16'(level), 16'h1);
      req  = 1'b1;
      mask = 8'hFF;
      tick();
      check("z_ack",   16'(ack),       16'h1);
      check("z_byte",  16'(rand_byte), 16'h00);
      check("z_level", 16'(level),     16'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
